conv_layer_scheduler: RTL

Layer-level scheduler that sequences the PE convolution MAC controller across one convolution layer. Walks every output position (row-major) and every output-channel group, issues one `pe_start` pulse per (position, group) to the PE controller's `buffer_valid` input, and advances the line-buffer window. Bounds outstanding PE jobs with an in-flight credit counter, drains on the last position, and signals layer completion. It sits between the layer top (start/done) and the line buffer plus PE MAC controller.

---
 rtl/conv_sched_pkg.sv | 24 ++
 rtl/conv_inflight_counter.sv | 44 ++++
 rtl/conv_layer_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and sizing helpers for the convolution layer scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StAdvance,
    StDrain,
    StDone
  } sched_state_t;

  // Output extent of one spatial dimension for a valid (unpadded) convolution.
  function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned kernel,
                                          input int unsigned stride);
    return (in_dim - kernel) / stride + 1;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_inflight_counter.sv
// Up/down credit counter tracking PE jobs issued but not yet completed.
module conv_inflight_counter
  import conv_sched_pkg::*;
#(
  parameter int unsigned pMAX = 4,
  localparam int unsigned CntW = cnt_w(pMAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            underflow_o
);

  localparam logic [CntW-1:0] CountMax = CntW'(pMAX);

  logic [CntW-1:0] count_q, count_d;

  // Next count; a completion with nothing outstanding is flagged and never wraps.
  always_comb begin
    count_d     = count_q;
    underflow_o = dec_i && (count_q == '0);
    if (inc_i && !dec_i) begin
      count_d = count_q + CntW'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CountMax);

endmodule

// File: rtl/conv_layer_scheduler.sv
// Walks output positions and channel groups of one conv layer, issuing PE jobs under a
// credit limit, then drains outstanding jobs and pulses done.
module conv_layer_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned pIN_WIDTH        = 8,
  parameter int unsigned pIN_HEIGHT       = 8,
  parameter int unsigned pKERNEL_SIZE     = 3,
  parameter int unsigned pSTRIDE          = 1,
  parameter int unsigned pOUT_CHANNEL     = 32,
  parameter int unsigned pOUTPUT_PARALLEL = 16,
  parameter int unsigned pMAX_INFLIGHT    = 4,
  localparam int unsigned OutW   = out_dim(pIN_WIDTH, pKERNEL_SIZE, pSTRIDE),
  localparam int unsigned OutH   = out_dim(pIN_HEIGHT, pKERNEL_SIZE, pSTRIDE),
  localparam int unsigned Groups = pOUT_CHANNEL / pOUTPUT_PARALLEL,
  localparam int unsigned ColW   = cnt_w(OutW),
  localparam int unsigned RowW   = cnt_w(OutH),
  localparam int unsigned GrpW   = cnt_w(Groups),
  localparam int unsigned InfW   = cnt_w(pMAX_INFLIGHT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            window_valid,
  output logic            window_req,
  input  logic            pe_ready,
  input  logic            pe_valid,
  output logic            pe_start,
  output logic [GrpW-1:0] buffer_idx,
  output logic [RowW-1:0] out_row,
  output logic [ColW-1:0] out_col,
  output logic [InfW-1:0] inflight,
  output logic            busy,
  output logic            done,
  output logic            err_underflow
);

  localparam logic [ColW-1:0] ColLast = ColW'(OutW - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(OutH - 1);
  localparam logic [GrpW-1:0] GrpLast = GrpW'(Groups - 1);

  sched_state_t    state_q, state_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [GrpW-1:0] grp_q, grp_d;
  logic            pe_start_q;
  logic            err_q;
  logic            cnt_full;
  logic            cnt_underflow;
  logic            last_pos;

  conv_inflight_counter #(
    .pMAX(pMAX_INFLIGHT)
  ) u_inflight (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (pe_start),
    .dec_i      (pe_valid),
    .count_o    (inflight),
    .full_o     (cnt_full),
    .underflow_o(cnt_underflow)
  );

  assign last_pos = (row_q == RowLast) && (col_q == ColLast);

  // Next-state, position/group stepping and strobes.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    grp_d      = grp_q;
    pe_start   = 1'b0;
    window_req = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          row_d   = '0;
          col_d   = '0;
          grp_d   = '0;
        end
      end
      StFetch: begin
        if (window_valid) state_d = StIssue;
      end
      StIssue: begin
        // The gap after each pulse gives the PE a clean rise and fall on buffer_valid.
        if (pe_ready && !cnt_full && !pe_start_q) begin
          pe_start = 1'b1;
          if (grp_q == GrpLast) begin
            grp_d   = '0;
            state_d = StAdvance;
          end else begin
            grp_d = grp_q + GrpW'(1);
          end
        end
      end
      StAdvance: begin
        window_req = !last_pos;
        if (col_q == ColLast) begin
          col_d = '0;
          row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
        end else begin
          col_d = col_q + ColW'(1);
        end
        state_d = last_pos ? StDrain : StFetch;
      end
      StDrain: begin
        if (inflight == '0) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters, pulse history and sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      grp_q      <= '0;
      pe_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      grp_q      <= grp_d;
      pe_start_q <= pe_start;
      if (cnt_underflow) err_q <= 1'b1;
    end
  end

  assign buffer_idx    = grp_q;
  assign out_row       = row_q;
  assign out_col       = col_q;
  assign busy          = (state_q != StIdle);
  assign err_underflow = err_q;

endmodule
